mips_program_loader: RTL

//   Writer side of the instruction-memory interface that the single-cycle MIPS core reads.

---
 rtl/mips_loader_pkg.sv | 11 +
 rtl/loader_word_packer.sv | 36 +++
 rtl/mips_program_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/mips_loader_pkg.sv
// Shared types and frame constants for the MIPS instruction-memory loader.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/loader_word_packer.sv
// Packs accepted stream bytes MSB-first into 32-bit words; word_valid is a
// combinational pulse on the handshake of the last byte of each word.
module loader_word_packer
    import mips_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] sr;
    logic [1:0]  cnt;

    // The final byte is spliced in directly so the top can register the word
    // on the same edge that consumes it.
    assign word_valid = byte_valid && (cnt == 2'(WORD_BYTES - 1));
    assign word       = {sr, byte_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (byte_valid) begin
            sr  <= {sr[15:0], byte_data};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/mips_program_loader.sv
// Loads a length-prefixed, XOR-checked byte image into instruction memory and
// holds the core in reset until the image verifies.
module mips_program_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [7:0]  chk;
    logic        xfer;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] len_n;
    logic        last_word;

    assign xfer      = rx_valid && rx_ready;
    assign len_n     = {len_hi, rx_data};
    assign last_word = ({1'b0, words_loaded} + 17'd1) == {1'b0, len};

    loader_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state != DATA),
        .byte_valid (xfer && (state == DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            len_hi       <= '0;
            len          <= '0;
            chk          <= '0;
        end else begin
            mem_we <= 1'b0;
            if (word_valid) begin
                mem_we       <= 1'b1;
                mem_addr     <= ADDR_WIDTH'(BASE_ADDR + 32'(words_loaded));
                mem_wdata    <= word;
                words_loaded <= words_loaded + 16'd1;
            end
            if (xfer && state == DATA)
                chk <= chk ^ rx_data;

            case (state)
                IDLE, DONE, ERROR: if (load_start) begin
                    state        <= LEN_HI;
                    rx_ready     <= 1'b1;
                    cpu_rst      <= 1'b1;
                    done         <= 1'b0;
                    error        <= 1'b0;
                    words_loaded <= '0;
                    chk          <= '0;
                end
                LEN_HI: if (xfer) begin
                    len_hi <= rx_data;
                    state  <= LEN_LO;
                end
                LEN_LO: if (xfer) begin
                    len <= len_n;
                    if ({1'b0, len_n} > CAPACITY) begin
                        state    <= ERROR;
                        rx_ready <= 1'b0;
                        error    <= 1'b1;
                    end else if (len_n == 16'd0) begin
                        state <= CHECK;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (word_valid && last_word)
                    state <= CHECK;
                CHECK: if (xfer) begin
                    rx_ready <= 1'b0;
                    if (rx_data == chk) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        state <= ERROR;
                        error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
